rv_regfile: RTL and testbench



---
 rtl/rv_regfile_if.sv | 24 ++
 rtl/rv_regfile.sv | 61 ++++++
 tb/tb_rv_regfile.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/rv_regfile_if.sv
// Register-file access bundle: decode drives read addresses, writeback drives the write port.
// The master modport belongs to the core pipeline; the slave modport belongs to the register file.
interface rv_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] rs1_addr;
  logic [ADDR_WIDTH-1:0] rs2_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  write_en;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;

  modport master (
    output rs1_addr, rs2_addr, rd_addr, rd_data, write_en,
    input  rs1_data, rs2_data
  );

  modport slave (
    input  rs1_addr, rs2_addr, rd_addr, rd_data, write_en,
    output rs1_data, rs2_data
  );
endinterface

// File: rtl/rv_regfile.sv
// RV32I integer register file: 2 combinational read ports, 1 synchronous write port, x0 reads zero.
// Optional RV_REGFILE_WRITE_BYPASS_EN forwards same-cycle write data to matching read ports.
module rv_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic          clk,
  input logic          rst_n,
  rv_regfile_if.slave  rf
);
  localparam int NREGS = 2 ** ADDR_WIDTH;

  // x0 has no storage; the array starts at index 1.
  logic [DATA_WIDTH-1:0] regs_q [1:NREGS-1];
  logic [DATA_WIDTH-1:0] regs_d [1:NREGS-1];
  logic                  wr_fire;

  // rst_n is active-high despite its name; a write coinciding with reset is dropped.
  assign wr_fire = rf.write_en && !rst_n && (rf.rd_addr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_fire) begin
      regs_d[rf.rd_addr] = rf.rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rf.rs1_data = '0;
    if (rf.rs1_addr != '0) begin
      rf.rs1_data = regs_q[rf.rs1_addr];
    end
`ifdef RV_REGFILE_WRITE_BYPASS_EN
    if (wr_fire && (rf.rs1_addr == rf.rd_addr)) begin
      rf.rs1_data = rf.rd_data;
    end
`endif
  end

  always_comb begin
    rf.rs2_data = '0;
    if (rf.rs2_addr != '0) begin
      rf.rs2_data = regs_q[rf.rs2_addr];
    end
`ifdef RV_REGFILE_WRITE_BYPASS_EN
    if (wr_fire && (rf.rs2_addr == rf.rd_addr)) begin
      rf.rs2_data = rf.rd_data;
    end
`endif
  end
endmodule

// File: tb/tb_rv_regfile.sv
// Self-checking bench for rv_regfile: directed vector table, full-sweep sequence, random run vs array model.
module tb_rv_regfile;
  logic clk;
  logic rst_n;

  rv_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf ();

  rv_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] d;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        chk;
    logic [31:0] e1;   // expected before the edge, no forwarding
    logic [31:0] e2;
    logic [31:0] b1;   // expected before the edge, with forwarding
    logic [31:0] b2;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mem [32];
  vec_t vecs [14];

`ifdef RV_REGFILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [4:0] rd,
                       input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2);
    rst_n       = rst;
    rf.write_en = we;
    rf.rd_addr  = rd;
    rf.rd_data  = d;
    rf.rs1_addr = a1;
    rf.rs2_addr = a2;
    #1;
  endtask

  // Advance one rising edge and update the architectural model from the applied inputs.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    end else if (rf.write_en && rf.rd_addr != 5'd0) begin
      mem[rf.rd_addr] = rf.rd_data;
    end
    #1;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (BYP && !rst_n && rf.write_en && rf.rd_addr != 5'd0 && a == rf.rd_addr)
      return rf.rd_data;
    return mem[a];
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);

    //          rst  we   rd     d              a1     a2     chk  e1            e2            b1            b2
    vecs[0]  = '{1'b1, 1'b0, 5'd0, 32'h0,        5'd1, 5'd5, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0};
    vecs[1]  = '{1'b0, 1'b1, 5'd1, 32'h1,        5'd1, 5'd5, 1'b1, 32'h0,        32'h0,        32'h1,        32'h0};
    vecs[2]  = '{1'b0, 1'b1, 5'd5, 32'hFFF,      5'd1, 5'd5, 1'b1, 32'h1,        32'h0,        32'h1,        32'hFFF};
    vecs[3]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd1, 5'd5, 1'b1, 32'h1,        32'hFFF,      32'h1,        32'hFFF};
    vecs[4]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd6, 1'b1, 32'h0,        32'h0,        32'h0,        32'h0};
    vecs[5]  = '{1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 1'b1, 32'h0,        32'h0,        32'h0,        32'h0};
    vecs[6]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd1, 1'b1, 32'h0,        32'h1,        32'h0,        32'h1};
    vecs[7]  = '{1'b0, 1'b1, 5'd2, 32'hF0F,      5'd2, 5'd2, 1'b1, 32'h0,        32'h0,        32'hF0F,      32'hF0F};
    vecs[8]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd2, 5'd5, 1'b1, 32'hF0F,      32'hFFF,      32'hF0F,      32'hFFF};
    vecs[9]  = '{1'b1, 1'b1, 5'd3, 32'h1234,     5'd3, 5'd2, 1'b1, 32'h0,        32'hF0F,      32'h0,        32'hF0F};
    vecs[10] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd1, 5'd2, 1'b1, 32'h0,        32'h0,        32'h0,        32'h0};
    vecs[11] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd3, 5'd5, 1'b1, 32'h0,        32'h0,        32'h0,        32'h0};
    vecs[12] = '{1'b0, 1'b1, 5'd3, 32'h55,       5'd3, 5'd0, 1'b1, 32'h0,        32'h0,        32'h55,       32'h0};
    vecs[13] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd3, 5'd3, 1'b1, 32'h55,       32'h55,       32'h55,       32'h55};

    for (int v = 0; v < 14; v++) begin
      drive(vecs[v].rst, vecs[v].we, vecs[v].rd, vecs[v].d, vecs[v].a1, vecs[v].a2);
      if (vecs[v].chk) begin
        check($sformatf("vec%0d_rs1", v), rf.rs1_data, BYP ? vecs[v].b1 : vecs[v].e1);
        check($sformatf("vec%0d_rs2", v), rf.rs2_data, BYP ? vecs[v].b2 : vecs[v].e2);
      end
      tick();
    end

    // Fill every register with address * 0x01010101, then sweep both ports.
    for (int a = 1; a < 32; a++) begin
      drive(1'b0, 1'b1, 5'(a), 32'(a) * 32'h01010101, 5'd0, 5'd0);
      tick();
    end
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
      check($sformatf("sweep_rs1_x%0d", a), rf.rs1_data, 32'(a) * 32'h01010101);
      check($sformatf("sweep_rs2_x%0d", 31 - a), rf.rs2_data, 32'(31 - a) * 32'h01010101);
    end

    // Random traffic with occasional reset and read/write address collisions.
    for (int n = 0; n < 2000; n++) begin
      logic        r_rst;
      logic        r_we;
      logic [4:0]  r_rd;
      logic [4:0]  r_a1;
      logic [4:0]  r_a2;
      r_rst = ($urandom_range(0, 63) == 0);
      r_we  = ($urandom_range(0, 3) != 0);
      r_rd  = 5'($urandom_range(0, 31));
      r_a1  = ($urandom_range(0, 3) == 0) ? r_rd : 5'($urandom_range(0, 31));
      r_a2  = ($urandom_range(0, 3) == 0) ? r_rd : 5'($urandom_range(0, 31));
      drive(r_rst, r_we, r_rd, $urandom, r_a1, r_a2);
      check("rand_rs1", rf.rs1_data, model_read(r_a1));
      check("rand_rs2", rf.rs2_data, model_read(r_a2));
      tick();
    end

    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int a = 0; a < 32; a++) begin
      rf.rs1_addr = 5'(a);
      #1;
      check("final_state", rf.rs1_data, (a == 0) ? 32'h0 : mem[a]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
